// File: rtl/match_tx_scheduler.sv
// Round-robin share of one transmitter match port: grant in the request cycle, m_match_valid next cycle, one packet in flight until tlast or watchdog.
// Requesters are stalled (s_match_ready low) while busy; optional MATCH_SCHED_PRIO0_EN gives requester 0 strict priority.
module match_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            clock_i,
    input  logic                            reset_ni,
    input  logic [NUM_REQ-1:0]              s_match_valid,
    output logic [NUM_REQ-1:0]              s_match_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_match_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    s_match_pkt_len,
    output logic                            m_match_valid,
    input  logic                            m_match_ready,
    output logic [ADDR_WIDTH-1:0]           m_match_addr,
    output logic [LEN_WIDTH-1:0]            m_match_pkt_len,
    input  logic                            mon_axis_tvalid,
    input  logic                            mon_axis_tready,
    input  logic                            mon_axis_tlast,
    output logic                            busy_o,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id_o,
    output logic                            err_timeout_o,
    input  logic                            err_clear_i,
    output logic [15:0]                     drop_cnt_o
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_grant_id;
    logic [WD_W-1:0]       r_wd_cnt;
    logic                  r_m_valid;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [LEN_WIDTH-1:0]  r_m_len;
    logic                  r_err;
    logic [15:0]           r_drop_cnt;

    logic                  w_found;
    logic                  w_upd_ptr;
    logic [ID_W-1:0]       w_win;
    logic [NUM_REQ-1:0]    w_onehot;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [LEN_WIDTH-1:0]  w_len;
    logic                  w_done;
    logic                  w_timeout;

    // Search starts one past the last winner and wraps.
    always_comb begin : p_arb
        int idx;
        w_found   = 1'b0;
        w_win     = '0;
        w_upd_ptr = 1'b1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx && !w_found && s_match_valid[i]) begin
                    w_found = 1'b1;
                    w_win   = ID_W'(i);
                end
            end
        end
`ifdef MATCH_SCHED_PRIO0_EN
        if (s_match_valid[0]) begin
            w_win     = '0;
            w_upd_ptr = 1'b0;
        end
`endif
    end

    always_comb begin
        w_addr   = '0;
        w_len    = '0;
        w_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found && ID_W'(i) == w_win) begin
                w_addr      = s_match_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_len       = s_match_pkt_len[i*LEN_WIDTH +: LEN_WIDTH];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_done    = mon_axis_tvalid & mon_axis_tready & mon_axis_tlast;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_WAIT_DONE) && !w_done
                       && (r_wd_cnt == WD_LAST);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_wd_cnt   <= '0;
            r_m_valid  <= 1'b0;
            r_m_addr   <= '0;
            r_m_len    <= '0;
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_m_addr   <= w_addr;
                        r_m_len    <= w_len;
                        r_grant_id <= w_win;
                        if (w_upd_ptr) r_rr_ptr <= w_win;
                        if (w_len != '0) begin
                            r_state   <= S_ISSUE;
                            r_m_valid <= 1'b1;
                        end else if (r_drop_cnt != 16'hFFFF) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (m_match_ready) begin
                        r_m_valid <= 1'b0;
                        r_wd_cnt  <= '0;
                        r_state   <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_done || w_timeout) r_state <= S_IDLE;
                    else r_wd_cnt <= r_wd_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
            // A timeout in the same cycle as a clear leaves the error set.
            if (w_timeout) r_err <= 1'b1;
            else if (err_clear_i) r_err <= 1'b0;
        end
    end

    assign s_match_ready   = (reset_ni && r_state == S_IDLE) ? w_onehot : '0;
    assign m_match_valid   = r_m_valid;
    assign m_match_addr    = r_m_addr;
    assign m_match_pkt_len = r_m_len;
    assign busy_o          = (r_state != S_IDLE);
    assign grant_id_o      = r_grant_id;
    assign err_timeout_o   = r_err;
    assign drop_cnt_o      = r_drop_cnt;
endmodule

// File: tb/tb_match_tx_scheduler.sv
// Bench for match_tx_scheduler: arbitration table, hand-written corner sequences and randomized transactions vs. a grant-order model.
module tb_match_tx_scheduler;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int LW = 16;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    s_valid, s_ready;
    logic [N*AW-1:0] s_addr;
    logic [N*LW-1:0] s_len;
    logic            m_valid, m_ready;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_len;
    logic            tv, tr, tl;
    logic            busy, err, err_clr;
    logic [1:0]      gid;
    logic [15:0]     drop;

    always #5 clk = ~clk;

    match_tx_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clock_i(clk), .reset_ni(rst_n),
        .s_match_valid(s_valid), .s_match_ready(s_ready),
        .s_match_addr(s_addr), .s_match_pkt_len(s_len),
        .m_match_valid(m_valid), .m_match_ready(m_ready),
        .m_match_addr(m_addr), .m_match_pkt_len(m_len),
        .mon_axis_tvalid(tv), .mon_axis_tready(tr), .mon_axis_tlast(tl),
        .busy_o(busy), .grant_id_o(gid), .err_timeout_o(err),
        .err_clear_i(err_clr), .drop_cnt_o(drop)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [AW-1:0] tb_addr [N];
    logic [LW-1:0] tb_len  [N];
    int m_last;   // model: last round-robin winner
    int m_drop;   // model: expected drop count

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] exp_rdy;
        logic [1:0] exp_gid;
        logic [7:0] exp_drop;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [N-1:0] mask);
        s_valid = mask;
        for (int i = 0; i < N; i++) begin
            s_addr[i*AW +: AW] = tb_addr[i];
            s_len[i*LW +: LW]  = tb_len[i];
        end
    endtask

    function automatic int exp_winner(input logic [N-1:0] mask, input int last);
`ifdef MATCH_SCHED_PRIO0_EN
        if (mask[0]) return 0;
`endif
        for (int k = 1; k <= N; k++)
            if (((mask >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
        return -1;
    endfunction

    function automatic void note_grant(input int w);
`ifdef MATCH_SCHED_PRIO0_EN
        if (w == 0) return;
`endif
        m_last = w;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; s_valid = '0; m_ready = 0; tv = 0; tr = 0; tl = 0; err_clr = 0;
        cyc(); cyc();
        rst_n = 1'b1;
        m_last = 0; m_drop = 0;
        cyc();
    endtask

    // One descriptor from request to completion; entered and left mid-cycle.
    task automatic do_txn(input logic [N-1:0] mask, input int bp, input int wt, input bit ign);
        int w; int r;
        logic [AW-1:0] ad; logic [LW-1:0] ln;
        drive_req(mask);
        #1;
        w = exp_winner(mask, m_last);
        check("txn_ready", s_ready, 64'(1) << w);
        note_grant(w);
        ad = tb_addr[w]; ln = tb_len[w];
        cyc();
        drive_req(mask & ~(4'b1 << w));
        #1;
        check("txn_gid", gid, w);
        if (ln == 0) begin
            m_drop++;
            check("txn_drop", drop, m_drop);
            check("txn_drop_novalid", m_valid, 0);
            check("txn_drop_idle", busy, 0);
            s_valid = '0;
            return;
        end
        check("txn_mvalid", m_valid, 1);
        check("txn_addr", m_addr, ad);
        check("txn_len", m_len, ln);
        check("txn_busy_ready", s_ready, 0);
        for (int i = 0; i <= bp; i++) begin
            m_ready = (i == bp);
            if (ign && i == 0) begin tv = 1; tr = 1; tl = 1; end
            cyc();
            m_ready = 0; tv = 0; tr = 0; tl = 0;
            #1;
            if (i < bp) begin
                check("hold_valid", m_valid, 1);
                check("hold_addr", m_addr, ad);
            end else begin
                check("accept_drop_valid", m_valid, 0);
                check("accept_busy", busy, 1);
            end
        end
        for (int j = 0; j < wt; j++) begin
            r = $urandom_range(0, 2);
            tv = (r == 1); tr = (r == 2); tl = 1;
            cyc();
            tv = 0; tr = 0; tl = 0;
            #1;
            check("wait_busy", busy, 1);
        end
        tv = 1; tr = 1; tl = 1;
        cyc();
        tv = 0; tr = 0; tl = 0;
        #1;
        check("done_idle", busy, 0);
        check("done_noerr", err, 0);
    endtask

    // Grant a single requester and accept at once; leaves the DUT in its first wait cycle.
    task automatic start_pkt(input int w, input logic [AW-1:0] ad, input logic [LW-1:0] ln);
        tb_addr[w] = ad; tb_len[w] = ln;
        drive_req(4'b1 << w);
        #1;
        check("start_ready", s_ready, 64'(1) << w);
        note_grant(w);
        cyc();
        s_valid = '0; m_ready = 1;
        #1;
        check("start_mvalid", m_valid, 1);
        cyc();
        m_ready = 0;
        #1;
        check("start_busy", busy, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k; bit err_early; int w;
`ifndef MATCH_SCHED_PRIO0_EN
        tbl[0] = '{4'b1111, 4'b0010, 2'd1, 8'd1};
        tbl[1] = '{4'b1111, 4'b0100, 2'd2, 8'd2};
        tbl[2] = '{4'b1111, 4'b1000, 2'd3, 8'd3};
        tbl[3] = '{4'b1111, 4'b0001, 2'd0, 8'd4};
        tbl[4] = '{4'b0001, 4'b0001, 2'd0, 8'd5};
        tbl[5] = '{4'b1001, 4'b1000, 2'd3, 8'd6};
        tbl[6] = '{4'b0110, 4'b0010, 2'd1, 8'd7};
        tbl[7] = '{4'b0000, 4'b0000, 2'd1, 8'd7};
        tbl[8] = '{4'b0101, 4'b0100, 2'd2, 8'd8};
        tbl[9] = '{4'b0011, 4'b0001, 2'd0, 8'd9};
`else
        tbl[0] = '{4'b1001, 4'b0001, 2'd0, 8'd1};
        tbl[1] = '{4'b1001, 4'b0001, 2'd0, 8'd2};
        tbl[2] = '{4'b1000, 4'b1000, 2'd3, 8'd3};
        tbl[3] = '{4'b1111, 4'b0001, 2'd0, 8'd4};
        tbl[4] = '{4'b1110, 4'b0010, 2'd1, 8'd5};
        tbl[5] = '{4'b0111, 4'b0001, 2'd0, 8'd6};
        tbl[6] = '{4'b0110, 4'b0100, 2'd2, 8'd7};
        tbl[7] = '{4'b1010, 4'b1000, 2'd3, 8'd8};
        tbl[8] = '{4'b0000, 4'b0000, 2'd3, 8'd8};
        tbl[9] = '{4'b0101, 4'b0001, 2'd0, 8'd9};
`endif
        for (int i = 0; i < N; i++) begin tb_addr[i] = AW'(8'h40 + i); tb_len[i] = LW'(i + 1); end
        rst_n = 1'b0; m_ready = 0; tv = 0; tr = 0; tl = 0; err_clr = 0;
        drive_req(4'b1111);
        #12;
        check("rst_ready", s_ready, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_gid", gid, 0);
        check("rst_err", err, 0);
        check("rst_drop", drop, 0);
        check("rst_addr", m_addr, 0);
        check("rst_len", m_len, 0);

        // Zero-length drops: arbitration order and drop counter, one grant per cycle.
        apply_reset();
        for (int i = 0; i < N; i++) tb_len[i] = '0;
        for (int r = 0; r < 10; r++) begin
            drive_req(tbl[r].valid);
            #1;
            check("tbl_ready", s_ready, tbl[r].exp_rdy);
            cyc();
            check("tbl_gid", gid, tbl[r].exp_gid);
            check("tbl_drop", drop, tbl[r].exp_drop);
            check("tbl_novalid", m_valid, 0);
        end
        s_valid = '0;

        // Single request with backpressure and late tlast.
        apply_reset();
        tb_addr[1] = 8'h10; tb_len[1] = 16'd4;
        do_txn(4'b0010, 3, 3, 1'b0);

        // Fairness with all requesters continuously valid.
        apply_reset();
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < N; i++) begin tb_addr[i] = AW'($urandom); tb_len[i] = LW'($urandom_range(1, 100)); end
            do_txn(4'b1111, 0, 1, 1'b0);
`ifndef MATCH_SCHED_PRIO0_EN
            check("fair_order", gid, (g + 1) % N);
`else
            check("fair_order", gid, 0);
`endif
        end
        s_valid = '0;

        // Zero-length then a real descriptor granted the following cycle.
        apply_reset();
        tb_len[2] = 16'd0; tb_len[3] = 16'd5;
        do_txn(4'b0100, 0, 0, 1'b0);
        do_txn(4'b1000, 1, 2, 1'b1);

        // Watchdog expiry, clear, completion on the last count, set beats clear.
        apply_reset();
        start_pkt(1, 8'h33, 16'd9);
        k = 0; err_early = 0;
        while (k < 40) begin
            cyc(); #1; k++;
            if (!busy) break;
            if (err) err_early = 1;
        end
        check("wd_cycles", k, TO);
        check("wd_err_set", err, 1);
        check("wd_err_early", err_early, 0);
        err_clr = 1; cyc(); err_clr = 0; #1;
        check("wd_err_clear", err, 0);
        start_pkt(2, 8'h44, 16'd3);
        for (int i = 0; i < TO - 1; i++) cyc();
        tv = 1; tr = 1; tl = 1;
        cyc();
        tv = 0; tr = 0; tl = 0;
        #1;
        check("wd_tie_idle", busy, 0);
        check("wd_tie_noerr", err, 0);
        start_pkt(3, 8'h55, 16'd2);
        err_clr = 1;
        k = 0;
        while (k < 40) begin
            cyc(); #1; k++;
            if (!busy) break;
        end
        check("wd2_cycles", k, TO);
        check("wd_set_wins", err, 1);
        err_clr = 0; cyc(); #1;
        check("wd_sticky", err, 1);

        // Asynchronous reset while waiting for completion.
        apply_reset();
        tb_len[1] = 16'd0;
        do_txn(4'b0010, 0, 0, 1'b0);
        start_pkt(2, 8'hA5, 16'd7);
        rst_n = 1'b0;
        drive_req(4'b1111);
        #1;
        check("arst_busy", busy, 0);
        check("arst_gid", gid, 0);
        check("arst_drop", drop, 0);
        check("arst_addr", m_addr, 0);
        check("arst_len", m_len, 0);
        check("arst_ready", s_ready, 0);
        cyc();
        rst_n = 1'b1; m_last = 0; m_drop = 0;
        #1;
        w = exp_winner(4'b1111, 0);
        check("arst_first_grant", s_ready, 64'(1) << w);
        s_valid = '0;

        // Randomized transactions against the grant-order model.
        apply_reset();
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                tb_addr[i] = AW'($urandom);
                tb_len[i]  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 500));
            end
            do_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 8),
                   1'($urandom_range(0, 1)));
        end
        s_valid = '0;

`ifdef MATCH_SCHED_PRIO0_EN
        apply_reset();
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < N; i++) tb_len[i] = LW'(g + 2);
            do_txn(4'b1001, 0, 1, 1'b0);
            check("prio_req0", gid, 0);
        end
        do_txn(4'b1000, 0, 1, 1'b0);
        check("prio_req3", gid, 3);
        s_valid = '0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/match_tx_scheduler.md
Name: match_tx_scheduler

Overview:
- Shares one packet_transmitter match port between NUM_REQ rule-match engines.
- Round-robin arbitration. Issues one descriptor (RAM address, packet length in 64-byte segments) at a time.
- Holds off further grants until the transmitter's AXI-Stream output shows end of packet (tlast beat) or a watchdog expires.
- Sits between the rule-match engines and packet_transmitter; snoops the transmitter's m_axis output.

Parameters:
- NUM_REQ, 4, number of requesting match engines (2..8).
- ADDR_WIDTH, 8, descriptor RAM start address width.
- LEN_WIDTH, 16, descriptor packet length width (segments).
- TIMEOUT_CYCLES, 4096, completion watchdog limit in clock cycles; 0 disables the watchdog.

Ports:
- clock_i  in  1  clock.
- reset_ni  in  1  reset.
- s_match_valid  in  NUM_REQ  per-requester descriptor valid.
- s_match_ready  out  NUM_REQ  per-requester accept.
- s_match_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_match_pkt_len  in  NUM_REQ*LEN_WIDTH  packed lengths.
- m_match_valid  out  1  descriptor to transmitter.
- m_match_ready  in  1  transmitter accept.
- m_match_addr  out  ADDR_WIDTH  issued address.
- m_match_pkt_len  out  LEN_WIDTH  issued length.
- mon_axis_tvalid  in  1  snooped transmitter tvalid.
- mon_axis_tready  in  1  snooped tready.
- mon_axis_tlast  in  1  snooped tlast.
- busy_o  out  1  descriptor in flight (state != S_IDLE).
- grant_id_o  out  $clog2(NUM_REQ)  requester of the last accepted descriptor.
- err_timeout_o  out  1  sticky watchdog error.
- err_clear_i  in  1  clears err_timeout_o.
- drop_cnt_o  out  16  count of dropped zero-length descriptors, saturating.

Behaviour:
- Reset: reset_ni is asynchronous, active-low; the clock is clock_i. The following are 0: all registered outputs, the state (S_IDLE), rr_ptr, and the watchdog counter. s_match_ready is 0 while in reset.
- States: S_IDLE, S_ISSUE, S_WAIT_DONE.
- Arbitration in S_IDLE:
  - Search valid requesters starting at (rr_ptr+1) mod NUM_REQ, ascending with wrap. The first hit wins.
  - s_match_ready is combinational: one-hot winner, asserted only in S_IDLE. At most one bit is ever set.
  - On that cycle, capture the winner's addr/len into m_match_addr/m_match_pkt_len.
  - Update rr_ptr and grant_id_o to the winner.
  - If len != 0, go to S_ISSUE.
  - If len == 0, drop the descriptor: stay in S_IDLE, increment drop_cnt_o (saturate at 16'hFFFF), rr_ptr still advances.
- S_ISSUE:
  - m_match_valid = 1. addr/len are held stable until m_match_ready is sampled high.
  - On m_match_valid & m_match_ready: m_match_valid <= 0, go to S_WAIT_DONE, clear the watchdog counter.
- S_WAIT_DONE:
  - Completion is mon_axis_tvalid & mon_axis_tready & mon_axis_tlast. On completion, go to S_IDLE.
  - Otherwise increment the watchdog counter. When it equals TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0), set err_timeout_o, go to S_IDLE.
  - Completion and timeout on the same cycle: completion wins, no error.
- Latency:
  - Request valid in S_IDLE at cycle t -> s_match_ready high at t.
  - m_match_valid high from t+1.
  - After completion, the next grant occurs no earlier than the cycle after returning to S_IDLE, so at least 1 idle cycle between descriptors.
- Requesters must hold valid and payload until ready. The block does not buffer more than one descriptor.
- Snooped tlast beats seen in S_IDLE or S_ISSUE are ignored.
- err_clear_i has priority below a same-cycle timeout set (set wins).
- Reset mid-operation: everything returns to reset values at once. An in-flight transmitter packet is not tracked after reset.

Optional Feature:
- Macro MATCH_SCHED_PRIO0_EN.
- When defined: requester 0 has strict priority. If s_match_valid[0] is high in S_IDLE, it wins regardless of rr_ptr, and rr_ptr is not updated. Other requesters arbitrate round-robin among themselves.
- When undefined: pure round-robin across all NUM_REQ.

Test Plan:
- Single request: req1 valid, addr 8'h10, len 4. Expected: s_match_ready=4'b0010 at t; m_match_valid at t+1 with addr 10/len 4; hold while m_match_ready=0 for 3 cycles; accept; tlast beat 4 cycles later -> busy_o falls next cycle.
- Fairness: all 4 requesters valid continuously, completion 2 cycles after each issue. Expected grant order 1,2,3,0,1... from reset rr_ptr=0.
- Zero length: req2 valid with len 0. Expected: ready pulses, no m_match_valid, drop_cnt_o=1, next valid requester granted the following cycle.
- Watchdog: TIMEOUT_CYCLES=16, no tlast. Expected: err_timeout_o set 16 cycles after issue, return to S_IDLE. Same-cycle tlast at count 15 -> no error. err_clear_i clears the error.
- Reset in S_WAIT_DONE: deassert reset_ni. Expected: all outputs 0 immediately; after release, first grant uses rr_ptr=0 ordering.
- With MATCH_SCHED_PRIO0_EN: req0 and req3 valid repeatedly. Expected: req0 always granted while valid; req3 served only when req0 is low.
